car_alarm_multizone: RTL and testbench

//   Next-generation anti-theft controller: NUM_DOORS door sensors, a per-zone trigger latch and a saturating trip

---
 rtl/car_alarm_multizone.sv | 130 +++++++++++++
 tb/tb_car_alarm_multizone.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/car_alarm_multizone.sv
// rtl/car_alarm_multizone.sv - multizone car alarm: entry/arm/hold timers in divided ticks, zone latch, trip counter
module car_alarm_multizone #(
    parameter int NUM_DOORS         = 4,
    parameter int TICK_DIV          = 4,
    parameter int TIMER_W           = 4,
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10,
    parameter int COUNT_W           = 8
) (
    input  logic                 clock,
    input  logic                 systemReset,
    input  logic                 ignition,
    input  logic                 brake,
    input  logic                 hidden,
    input  logic [NUM_DOORS-1:0] door,
    output logic                 fuelPumpPower,
    output logic                 statusIndicator,
    output logic                 siren,
    output logic [NUM_DOORS-1:0] alarm_zone,
    output logic [COUNT_W-1:0]   trip_count
);
    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        ARMED, ENTRY, ALARM, HOLD, DIS_ON, DIS_OFF, DIS_DOOR, ARM_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, load_val;
    logic [DIV_W-1:0]   divider;
    logic               load, tick, expired, any_door, trip_inc, led_nxt;

    assign tick     = (divider == DIV_W'(TICK_DIV - 1));
    assign expired  = (timer == '0);
    assign any_door = |door;

    always_ff @(posedge clock or posedge systemReset) begin
        if (systemReset) begin
            state <= ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // Ignition wins over everything; an open door wins over expiry.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = '0;
        trip_inc  = 1'b0;
        if (ignition) begin
            state_nxt = DIS_ON;
        end else begin
            case (state)
                ARMED: if (any_door) begin
                    state_nxt = ENTRY;
                    load      = 1'b1;
                    load_val  = door[0] ? TIMER_W'(T_DRIVER_DELAY) : TIMER_W'(T_PASSENGER_DELAY);
                end
                ENTRY: if (expired) begin
                    state_nxt = ALARM;
                    trip_inc  = 1'b1;
                end
                ALARM: if (!any_door) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                    load_val  = TIMER_W'(T_ALARM_ON);
                end
                HOLD: begin
                    if (any_door)     state_nxt = ALARM;
                    else if (expired) state_nxt = ARMED;
                end
                DIS_ON:  state_nxt = DIS_OFF;
                DIS_OFF: if (door[0]) state_nxt = DIS_DOOR;
                DIS_DOOR: if (!any_door) begin
                    state_nxt = ARM_WAIT;
                    load      = 1'b1;
                    load_val  = TIMER_W'(T_ARM_DELAY);
                end
                ARM_WAIT: begin
                    if (any_door)     state_nxt = DIS_DOOR;
                    else if (expired) state_nxt = ARMED;
                end
                default: state_nxt = ARMED;
            endcase
        end
    end

    // The LED starts dark on entering ARMED and then blinks on each tick.
    always_comb begin
        led_nxt = statusIndicator;
        case (state_nxt)
            ENTRY, ALARM, HOLD, ARM_WAIT: led_nxt = 1'b1;
            DIS_ON, DIS_OFF, DIS_DOOR:    led_nxt = 1'b0;
            default: led_nxt = (state != ARMED) ? 1'b0 : (tick ? ~statusIndicator : statusIndicator);
        endcase
    end

    always_ff @(posedge clock or posedge systemReset) begin
        if (systemReset) begin
            timer           <= '0;
            divider         <= '0;
            alarm_zone      <= '0;
            trip_count      <= '0;
            siren           <= 1'b0;
            fuelPumpPower   <= 1'b0;
            statusIndicator <= 1'b0;
        end else begin
            if (load) begin
                timer   <= load_val;
                divider <= '0;
            end else begin
                divider <= tick ? '0 : divider + 1'b1;
                if (tick && !expired) timer <= timer - 1'b1;
            end
            if (ignition) begin
                alarm_zone <= '0;
            end else if (state == ENTRY || state == ALARM || state == HOLD) begin
                alarm_zone <= alarm_zone | door;
            end
            if (trip_inc && trip_count != '1) trip_count <= trip_count + 1'b1;
            siren           <= (state_nxt == ALARM) || (state_nxt == HOLD);
            statusIndicator <= led_nxt;
            if (!ignition)           fuelPumpPower <= 1'b0;
            else if (hidden && brake) fuelPumpPower <= 1'b1;
        end
    end
endmodule

// File: tb/tb_car_alarm_multizone.sv
// tb/tb_car_alarm_multizone.sv - self-checking bench for car_alarm_multizone
module tb_car_alarm_multizone;
    localparam int TD    = 4;
    localparam int T_DRV = 8;
    localparam int T_PAS = 15;
    localparam int T_ON  = 10;
    localparam int T_ARM = 6;

    logic       clock = 1'b0;
    logic       systemReset, ignition, brake, hidden;
    logic [3:0] door;
    logic       fp, led, siren, fp2, led2, siren2;
    logic [3:0] zone, zone2;
    logic [7:0] trip;
    logic [1:0] trip2;

    car_alarm_multizone dut (
        .clock(clock), .systemReset(systemReset), .ignition(ignition), .brake(brake),
        .hidden(hidden), .door(door), .fuelPumpPower(fp), .statusIndicator(led),
        .siren(siren), .alarm_zone(zone), .trip_count(trip)
    );

    car_alarm_multizone #(.COUNT_W(2)) dut2 (
        .clock(clock), .systemReset(systemReset), .ignition(ignition), .brake(brake),
        .hidden(hidden), .door(door), .fuelPumpPower(fp2), .statusIndicator(led2),
        .siren(siren2), .alarm_zone(zone2), .trip_count(trip2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: named modes, a remaining-cycle countdown and a tick phase counter.
    string      ms, nxt;
    int         rem, ph, ld, m_trip, m_trip2;
    logic       m_led, m_pump, mtick;
    logic [3:0] m_zone;

    always @(posedge clock or posedge systemReset) begin
        if (systemReset) begin
            ms = "ARMED"; rem = 0; ph = 0; m_led = 1'b0; m_pump = 1'b0;
            m_zone = 4'b0; m_trip = 0; m_trip2 = 0;
        end else begin
            mtick = (ph == TD - 1);
            nxt = ms;
            ld = -1;
            if (ignition) nxt = "DIS_ON";
            else if (ms == "ARMED") begin
                if (door != 0) begin nxt = "ENTRY"; ld = door[0] ? T_DRV : T_PAS; end
            end else if (ms == "ENTRY") begin
                if (rem == 0) nxt = "ALARM";
            end else if (ms == "ALARM") begin
                if (door == 0) begin nxt = "HOLD"; ld = T_ON; end
            end else if (ms == "HOLD") begin
                if (door != 0) nxt = "ALARM";
                else if (rem == 0) nxt = "ARMED";
            end else if (ms == "DIS_ON") nxt = "DIS_OFF";
            else if (ms == "DIS_OFF") begin
                if (door[0]) nxt = "DIS_DOOR";
            end else if (ms == "DIS_DOOR") begin
                if (door == 0) begin nxt = "ARM_WAIT"; ld = T_ARM; end
            end else begin
                if (door != 0) nxt = "DIS_DOOR";
                else if (rem == 0) nxt = "ARMED";
            end

            if (ms == "ENTRY" && nxt == "ALARM") begin
                m_trip  = (m_trip < 255) ? m_trip + 1 : 255;
                m_trip2 = (m_trip2 < 3) ? m_trip2 + 1 : 3;
            end
            if (ignition) m_zone = 4'b0;
            else if (ms == "ENTRY" || ms == "ALARM" || ms == "HOLD") m_zone = m_zone | door;
            if (!ignition) m_pump = 1'b0;
            else if (hidden && brake) m_pump = 1'b1;
            if (nxt == "ENTRY" || nxt == "ALARM" || nxt == "HOLD" || nxt == "ARM_WAIT") m_led = 1'b1;
            else if (nxt == "ARMED") m_led = (ms != "ARMED") ? 1'b0 : (mtick ? ~m_led : m_led);
            else m_led = 1'b0;
            if (ld >= 0) begin
                rem = ld * TD;
                ph  = 0;
            end else begin
                if (rem > 0) rem--;
                ph = (ph + 1) % TD;
            end
            ms = nxt;
        end
    end

    always @(posedge clock) begin
        #1;
        chk("siren", siren, (ms == "ALARM" || ms == "HOLD"));
        chk("led", led, m_led);
        chk("pump", fp, m_pump);
        chk("zone", zone, m_zone);
        chk("trip", trip, m_trip);
        chk("siren2", siren2, (ms == "ALARM" || ms == "HOLD"));
        chk("led2", led2, m_led);
        chk("pump2", fp2, m_pump);
        chk("zone2", zone2, m_zone);
        chk("trip2", trip2, m_trip2);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts consecutive negedges (from the next one) where the selected output equals val.
    task automatic run_len(input int sel, input logic val, output int n);
        n = 0;
        @(negedge clock);
        while (((sel == 0) ? siren : led) === val && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    int n;
    int exp2[4] = '{1, 2, 3, 3};

    initial begin
        systemReset = 1'b1; ignition = 1'b0; brake = 1'b0; hidden = 1'b0; door = 4'b0011;
        cyc(3);
        chk("rst_siren", siren, 0);
        chk("rst_pump", fp, 0);
        chk("rst_trip", trip, 0);
        systemReset = 1'b0; door = 4'b0;
        cyc(3); chk("armed_led_a", led, 0);
        cyc(1); chk("armed_led_b", led, 1);
        cyc(4); chk("armed_led_c", led, 0);
        chk("armed_siren", siren, 0);

        ignition = 1'b1;
        cyc(1); chk("dis_on_led", led, 0);
        hidden = 1'b1; brake = 1'b1;
        cyc(1); chk("pump_on", fp, 1);
        hidden = 1'b0; brake = 1'b0;
        cyc(2); chk("pump_hold", fp, 1);
        ignition = 1'b0;
        cyc(1); chk("pump_off", fp, 0); chk("dis_off_led", led, 0);
        door = 4'b0001;
        cyc(1);
        door = 4'b0;
        run_len(1, 1'b1, n); chk("arm_wait_len", n, 25);
        cyc(3); chk("rearmed_blink", led, 1);

        door = 4'b0001;
        run_len(0, 1'b0, n); chk("driver_entry_len", n, 33);
        chk("trip_1", trip, 1);
        chk("zone_driver", zone, 4'b0001);
        chk("model_trip_1", m_trip, 1);

        door = 4'b0;
        run_len(0, 1'b1, n); chk("hold_len", n, 41);
        chk("post_hold_led", led, 0);
        door = 4'b0001;
        run_len(0, 1'b0, n); chk("driver_entry_len2", n, 33);
        chk("trip_2", trip, 2);
        door = 4'b0;
        cyc(20);
        door = 4'b0010;
        cyc(1); chk("rearm_alarm", siren, 1);
        door = 4'b0;
        run_len(0, 1'b1, n); chk("hold_len_rearmed", n, 41);
        chk("zone_or", zone, 4'b0011);
        chk("model_zone", m_zone, 4'b0011);

        door = 4'b0100;
        cyc(40);
        ignition = 1'b1;
        cyc(1);
        chk("ign_siren", siren, 0);
        chk("ign_zone", zone, 0);
        chk("ign_led", led, 0);
        ignition = 1'b0; door = 4'b0001;
        cyc(2);
        door = 4'b0;
        cyc(30);

        systemReset = 1'b1;
        cyc(1); chk("rst2_trip", trip, 0); chk("rst2_trip2", trip2, 0);
        systemReset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            door = 4'b0001;
            run_len(0, 1'b0, n); chk("sat_entry_len", n, 33);
            chk("sat_trip2", trip2, exp2[k]);
            chk("sat_trip8", trip, k + 1);
            if (k < 3) begin
                door = 4'b0;
                run_len(0, 1'b1, n); chk("sat_hold_len", n, 41);
            end
        end
        cyc(2);
        systemReset = 1'b1;
        #1;
        chk("async_siren", siren, 0);
        chk("async_siren2", siren2, 0);
        chk("async_trip2", trip2, 0);
        cyc(1);
        systemReset = 1'b0; door = 4'b0;
        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
